data_mem_arbiter: RTL

Arbiter that shares the single 1024×32 data memory between the pipeline's memory stage and an auxiliary requester (program loader / debug port). It sits between the memory stage's access signals and the data memory.
- The pipeline has fixed priority.
- A starvation counter guarantees aux progress by stalling the pipeline for one cycle when the aux requester has waited too long.

---
 rtl/data_mem_arbiter_pkg.sv | 20 ++
 rtl/data_mem_arbiter_if.sv | 57 +++++
 rtl/data_mem_arbiter_starve_counter.sv | 37 +++
 rtl/data_mem_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter_pkg
//  Description : Shared types and defaults for the data memory arbiter and
//                the pipeline memory stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_arbiter_pkg;

    localparam int c_DEFAULT_ADDR_W = 10;
    localparam int c_DEFAULT_DATA_W = 32;
    localparam int c_STARVE_CNT_W   = 4;

    typedef enum logic [0:0] {
        GRANT_PIPE = 1'b0,
        FORCE_AUX  = 1'b1
    } arbState_e;

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter_if
//  Description : Pipe, aux and data-memory signals of the arbiter. The slave
//                modport is the arbiter view, master is the surroundings.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_arbiter_if
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = c_DEFAULT_ADDR_W,
    parameter int DATA_W = c_DEFAULT_DATA_W
);
    logic              pipeRead;
    logic              pipeWrite;
    logic [ADDR_W-1:0] pipeAddr;
    logic [DATA_W-1:0] pipeWData;
    logic [DATA_W-1:0] pipeRData;
    logic              pipeStall;

    logic              auxValid;
    logic              auxWrite;
    logic [ADDR_W-1:0] auxAddr;
    logic [DATA_W-1:0] auxWData;
    logic              auxReady;
    logic              auxRespValid;
    logic [DATA_W-1:0] auxRData;

    logic              memWrEnable;
    logic [ADDR_W-1:0] memWrAddress;
    logic [DATA_W-1:0] memWrData;
    logic              memRdEnable;
    logic [ADDR_W-1:0] memRdAddress;
    logic [DATA_W-1:0] memRdData;

    modport slave (
        input  pipeRead, pipeWrite, pipeAddr, pipeWData,
        output pipeRData, pipeStall,
        input  auxValid, auxWrite, auxAddr, auxWData,
        output auxReady, auxRespValid, auxRData,
        output memWrEnable, memWrAddress, memWrData,
        output memRdEnable, memRdAddress,
        input  memRdData
    );

    modport master (
        output pipeRead, pipeWrite, pipeAddr, pipeWData,
        input  pipeRData, pipeStall,
        output auxValid, auxWrite, auxAddr, auxWData,
        input  auxReady, auxRespValid, auxRData,
        input  memWrEnable, memWrAddress, memWrData,
        input  memRdEnable, memRdAddress,
        output memRdData
    );

endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
//  Module      : starve_counter
//  Description : Saturating count of consecutive blocked aux cycles; o_hit
//                flags the last blocked cycle before a forced aux grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module starve_counter
    import data_mem_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  wire  clk,
    input  wire  rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_hit
);
    localparam logic [c_STARVE_CNT_W-1:0] c_HIT_VALUE = c_STARVE_CNT_W'(LIMIT - 1);

    logic [c_STARVE_CNT_W-1:0] r_count;

    // Clear wins over increment; saturate instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_hit = (r_count == c_HIT_VALUE);

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter
//  Description : Shares the data memory between the pipeline memory stage
//                (fixed priority) and an aux requester, with a one-cycle
//                forced aux grant after STARVE_LIMIT blocked cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = c_DEFAULT_ADDR_W,
    parameter int DATA_W       = c_DEFAULT_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  wire              clk,
    input  wire              rst,
    data_mem_arbiter_if.slave bus
);
    arbState_e         r_state;
    logic              r_auxRespValid;
    logic [DATA_W-1:0] r_auxRData;

    logic              w_pipeActive;
    logic              w_auxOwns;
    logic              w_auxReady;
    logic              w_auxReadAccept;
    logic              w_pipeStall;
    logic [DATA_W-1:0] w_pipeRData;
    logic              w_memWrEnable;
    logic [ADDR_W-1:0] w_memWrAddress;
    logic [DATA_W-1:0] w_memWrData;
    logic              w_memRdEnable;
    logic [ADDR_W-1:0] w_memRdAddress;
    logic              w_cntInc;
    logic              w_cntClr;
    logic              w_starveHit;

    assign w_pipeActive    = bus.pipeRead | bus.pipeWrite;
    assign w_auxReadAccept = w_auxReady & ~bus.auxWrite;

    // Memory port steering; everything is held idle while reset is asserted
    always_comb begin
        w_auxOwns      = 1'b0;
        w_pipeStall    = 1'b0;
        w_pipeRData    = '0;
        w_memWrEnable  = 1'b0;
        w_memWrAddress = '0;
        w_memWrData    = '0;
        w_memRdEnable  = 1'b0;
        w_memRdAddress = '0;
        if (!rst) begin
            case (r_state)
                GRANT_PIPE: begin
                    if (w_pipeActive) begin
                        w_memWrEnable  = bus.pipeWrite;
                        w_memWrAddress = bus.pipeAddr;
                        w_memWrData    = bus.pipeWData;
                        w_memRdEnable  = bus.pipeRead;
                        w_memRdAddress = bus.pipeAddr;
                        w_pipeRData    = bus.pipeRead ? bus.memRdData : '0;
                    end else begin
                        w_auxOwns = bus.auxValid;
                    end
                end
                FORCE_AUX: begin
                    w_pipeStall = 1'b1;
                    w_auxOwns   = bus.auxValid;
                end
                default: ;
            endcase
            if (w_auxOwns) begin
                w_memWrEnable  = bus.auxWrite;
                w_memWrAddress = bus.auxAddr;
                w_memWrData    = bus.auxWData;
                w_memRdEnable  = ~bus.auxWrite;
                w_memRdAddress = bus.auxAddr;
            end
        end
    end

    assign w_auxReady = w_auxOwns;

    // Count only cycles where aux is blocked by an active pipe access
    assign w_cntInc = (r_state == GRANT_PIPE) & bus.auxValid & w_pipeActive;
    assign w_cntClr = w_auxReady | ~bus.auxValid | (r_state == FORCE_AUX);

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starveCounter (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_cntInc),
        .i_clr (w_cntClr),
        .o_hit (w_starveHit)
    );

    // Arbitration state and registered aux read response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= GRANT_PIPE;
            r_auxRespValid <= 1'b0;
            r_auxRData     <= '0;
        end else begin
            r_auxRespValid <= w_auxReadAccept;
            if (w_auxReadAccept) begin
                r_auxRData <= bus.memRdData;
            end
            case (r_state)
                GRANT_PIPE: if (w_cntInc && w_starveHit) r_state <= FORCE_AUX;
                FORCE_AUX:  r_state <= GRANT_PIPE;
                default:    r_state <= GRANT_PIPE;
            endcase
        end
    end

    assign bus.pipeRData    = w_pipeRData;
    assign bus.pipeStall    = w_pipeStall;
    assign bus.auxReady     = w_auxReady;
    assign bus.auxRespValid = r_auxRespValid;
    assign bus.auxRData     = r_auxRData;
    assign bus.memWrEnable  = w_memWrEnable;
    assign bus.memWrAddress = w_memWrAddress;
    assign bus.memWrData    = w_memWrData;
    assign bus.memRdEnable  = w_memRdEnable;
    assign bus.memRdAddress = w_memRdAddress;

endmodule
`default_nettype wire
